// File: rtl/vec_mem_sequencer.sv
// Vector load/store sequencer: splits a vector access into strided element accesses on the
// single data-memory port, stalls the CPU meanwhile and passes scalar traffic through otherwise.
module vec_mem_sequencer #(
    parameter int NUM_ELEM = 4,
    parameter int ELEM_W   = 32,
    parameter int ADDR_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_req,
    input  logic                       s_we,
    input  logic [ADDR_W-1:0]          s_addr,
    input  logic [ELEM_W-1:0]          s_wdata,
    output logic                       s_gnt,
    output logic [ELEM_W-1:0]          s_rdata,
    input  logic                       v_start,
    input  logic                       v_we,
    input  logic [ADDR_W-1:0]          v_base,
    input  logic [ADDR_W-1:0]          v_stride,
    input  logic [NUM_ELEM*ELEM_W-1:0] v_wdata,
    output logic [NUM_ELEM*ELEM_W-1:0] v_rdata,
    output logic                       v_done,
    output logic                       cpu_stall,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [ELEM_W-1:0]          mem_wdata,
    input  logic [ELEM_W-1:0]          mem_rdata
);

    localparam int IDX_W = $clog2(NUM_ELEM + 1);
    localparam int VEC_W = NUM_ELEM * ELEM_W;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx;
    logic                lat_we;
    logic [ADDR_W-1:0]   lat_base;
    logic [ADDR_W-1:0]   lat_stride;
    logic [VEC_W-1:0]    lat_wdata;
    logic [VEC_W-1:0]    rdata_q;
    logic                last_elem;
    logic [ADDR_W-1:0]   elem_addr;
    logic [ELEM_W-1:0]   elem_wdata;

    assign last_elem = (idx == IDX_W'(NUM_ELEM - 1));
    // Modular arithmetic makes a negative two's-complement stride wrap naturally.
    assign elem_addr = lat_base + ADDR_W'(idx) * lat_stride;
    assign v_rdata   = rdata_q;

    always_comb begin
        elem_wdata = '0;
        for (int i = 0; i < NUM_ELEM; i++) begin
            if (idx == IDX_W'(i)) elem_wdata = lat_wdata[i*ELEM_W +: ELEM_W];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            rdata_q <= '0;
        end else if (state == IDLE && v_start) begin
            idx <= '0;
        end else if (state == ACCESS) begin
            idx <= idx + 1'b1;
            if (!lat_we) begin
                for (int i = 0; i < NUM_ELEM; i++) begin
                    if (idx == IDX_W'(i)) rdata_q[i*ELEM_W +: ELEM_W] <= mem_rdata;
                end
            end
        end
    end

    // NOTE: operand latches carry no reset; they are only consumed in ACCESS, which is
    // always entered through the load below, so resetting them would only cost flops.
    always_ff @(posedge clk) begin
        if (state == IDLE && v_start) begin
            lat_we     <= v_we;
            lat_base   <= v_base;
            lat_stride <= v_stride;
            lat_wdata  <= v_wdata;
        end
    end

    // NOTE: every output and the next state get a default first, so no path through the
    // case statement can leave a variable unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        s_gnt     = 1'b0;
        s_rdata   = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = s_addr;
        mem_wdata = s_wdata;
        cpu_stall = 1'b0;
        v_done    = 1'b0;

        if (state != ACCESS) begin
            s_gnt     = s_req;
            s_rdata   = mem_rdata;
            mem_read  = s_req & ~s_we;
            mem_write = s_req & s_we;
        end

        unique case (state)
            IDLE: begin
                if (v_start) begin
                    cpu_stall = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                cpu_stall = 1'b1;
                mem_addr  = elem_addr;
                mem_wdata = elem_wdata;
                // A reset arriving mid-vector must not let the in-flight element reach memory.
                mem_read  = ~lat_we & ~rst;
                mem_write = lat_we & ~rst;
                if (last_elem) state_nxt = DONE;
            end
            DONE: begin
                v_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: scalar vector table, directed vector sequences
// and randomized instructions checked against a transaction-level memory model.
module tb_vec_mem_sequencer;

    localparam int N  = 4;
    localparam int EW = 32;
    localparam int AW = 32;
    localparam int VW = N * EW;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_req, s_we, s_gnt;
    logic [AW-1:0] s_addr;
    logic [EW-1:0] s_wdata, s_rdata;
    logic          v_start, v_we, v_done, cpu_stall;
    logic [AW-1:0] v_base, v_stride;
    logic [VW-1:0] v_wdata, v_rdata;
    logic          mem_read, mem_write;
    logic [AW-1:0] mem_addr;
    logic [EW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    vec_mem_sequencer #(.NUM_ELEM(N), .ELEM_W(EW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_gnt(s_gnt), .s_rdata(s_rdata),
        .v_start(v_start), .v_we(v_we), .v_base(v_base), .v_stride(v_stride),
        .v_wdata(v_wdata), .v_rdata(v_rdata), .v_done(v_done), .cpu_stall(cpu_stall),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // mem: contents as written by the DUT; ref_mem: contents the model says it should hold.
    logic [EW-1:0] mem     [logic [AW-1:0]];
    logic [EW-1:0] ref_mem [logic [AW-1:0]];
    logic [VW-1:0] exp_vrdata;
    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    typedef struct {
        logic          s_req;
        logic          s_we;
        logic [AW-1:0] s_addr;
        logic [EW-1:0] s_wdata;
        logic          e_gnt;
        logic          e_rd;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [EW-1:0] e_wdata;
        logic [EW-1:0] e_rdata;
    } vec_t;

    function automatic logic [EW-1:0] bg(input logic [AW-1:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [EW-1:0] dut_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : bg(a);
    endfunction

    function automatic logic [EW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : bg(a);
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [EW-1:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    task automatic settle();
        #2;
        mem_rdata = dut_rd(mem_addr);
        #2;
    endtask

    task automatic tick();
        logic          w;
        logic [AW-1:0] a;
        logic [EW-1:0] d;
        w = mem_write;
        a = mem_addr;
        d = mem_wdata;
        @(posedge clk);
        #1;
        if (w === 1'b1) begin
            mem[a] = d;
            wr_count++;
        end
    endtask

    task automatic idle_inputs();
        s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
        v_start = 1'b0; v_we = 1'b0; v_base = '0; v_stride = '0; v_wdata = '0;
    endtask

    task automatic scalar_op(input logic we, input logic [AW-1:0] addr, input logic [EW-1:0] data);
        s_req = 1'b1; s_we = we; s_addr = addr; s_wdata = data; v_start = 1'b0;
        settle();
        check("scalar gnt", VW'(s_gnt), VW'(1'b1));
        check("scalar addr", VW'(mem_addr), VW'(addr));
        check("scalar rd/wr", VW'({mem_read, mem_write}), VW'({~we, we}));
        if (we) check("scalar wdata", VW'(mem_wdata), VW'(data));
        else    check("scalar rdata", VW'(s_rdata), VW'(ref_rd(addr)));
        tick();
        s_req = 1'b0;
        if (we) begin
            ref_mem[addr] = data;
            check("scalar stored", VW'(dut_rd(addr)), VW'(ref_rd(addr)));
        end
    endtask

    // One vector instruction held by the CPU until v_done; optional scalar load that starts
    // presenting at cycle sc_cyc (cycle 0 = v_start cycle) and stays until the instruction ends.
    task automatic run_vec(input string tag, input logic we, input logic [AW-1:0] base,
                           input logic [AW-1:0] stride, input logic [VW-1:0] wdata,
                           input int sc_cyc, input logic [AW-1:0] sc_addr);
        logic [VW-1:0] exp_ld;
        logic [AW-1:0] ea;
        int            w0;
        for (int i = 0; i < N; i++) exp_ld[i*EW +: EW] = ref_rd(base + stride * AW'(i));
        w0 = wr_count;
        v_start = 1'b1; v_we = we; v_base = base; v_stride = stride; v_wdata = wdata;
        for (int cyc = 0; cyc <= N + 1; cyc++) begin
            s_req  = (sc_cyc >= 0 && cyc >= sc_cyc);
            s_we   = 1'b0;
            s_addr = sc_addr;
            settle();
            check($sformatf("%s c%0d stall", tag, cyc), VW'(cpu_stall), VW'(cyc <= N));
            check($sformatf("%s c%0d done", tag, cyc), VW'(v_done), VW'(cyc == N + 1));
            if (cyc >= 1 && cyc <= N) begin
                ea = base + stride * AW'(cyc - 1);
                check($sformatf("%s c%0d addr", tag, cyc), VW'(mem_addr), VW'(ea));
                check($sformatf("%s c%0d rd/wr", tag, cyc), VW'({mem_read, mem_write}), VW'({~we, we}));
                if (we) check($sformatf("%s c%0d wdata", tag, cyc), VW'(mem_wdata), VW'(wdata[(cyc-1)*EW +: EW]));
                check($sformatf("%s c%0d s_gnt", tag, cyc), VW'(s_gnt), VW'(1'b0));
                check($sformatf("%s c%0d s_rdata", tag, cyc), VW'(s_rdata), VW'(0));
            end else begin
                check($sformatf("%s c%0d s_gnt", tag, cyc), VW'(s_gnt), VW'(s_req));
                check($sformatf("%s c%0d rd/wr", tag, cyc), VW'({mem_read, mem_write}), VW'({s_req, 1'b0}));
                if (s_req) begin
                    check($sformatf("%s c%0d s_addr", tag, cyc), VW'(mem_addr), VW'(sc_addr));
                    check($sformatf("%s c%0d s_rdata", tag, cyc), VW'(s_rdata), VW'(ref_rd(sc_addr)));
                end
            end
            if (cyc == N + 1)
                check($sformatf("%s v_rdata", tag), v_rdata, we ? exp_vrdata : exp_ld);
            tick();
            if (we && cyc >= 1 && cyc <= N) ref_mem[base + stride * AW'(cyc - 1)] = wdata[(cyc-1)*EW +: EW];
        end
        v_start = 1'b0;
        s_req   = 1'b0;
        if (!we) exp_vrdata = exp_ld;
        check($sformatf("%s writes", tag), VW'(wr_count - w0), VW'(we ? N : 0));
        if (we) begin
            for (int i = 0; i < N; i++) begin
                ea = base + stride * AW'(i);
                check($sformatf("%s mem[%0h]", tag, ea), VW'(dut_rd(ea)), VW'(ref_rd(ea)));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t          tbl [6];
        logic [VW-1:0] wd;
        logic [AW-1:0] base, stride;
        int            w0;

        idle_inputs();
        mem_rdata  = '0;
        exp_vrdata = '0;
        rst = 1'b1;
        tick();
        tick();
        settle();
        check("reset stall", VW'(cpu_stall), VW'(1'b0));
        check("reset done", VW'(v_done), VW'(1'b0));
        check("reset v_rdata", v_rdata, VW'(0));
        check("reset rd/wr", VW'({mem_read, mem_write}), VW'(0));
        check("reset s_gnt", VW'(s_gnt), VW'(0));
        rst = 1'b0;
        tick();

        // Scalar pass-through table (IDLE only).
        preload(32'h40, 32'hCAFE_0001);
        tbl[0] = '{1'b0, 1'b0, 32'h40,   32'h0,         1'b0, 1'b0, 1'b0, 32'h40,   32'h0,         32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'h40,   32'h0,         1'b1, 1'b1, 1'b0, 32'h40,   32'h0,         32'hCAFE_0001};
        tbl[2] = '{1'b1, 1'b1, 32'h44,   32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h44,   32'h1234_5678, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h44,   32'h0,         1'b1, 1'b1, 1'b0, 32'h44,   32'h0,         32'h1234_5678};
        tbl[4] = '{1'b0, 1'b1, 32'h48,   32'hDEAD,      1'b0, 1'b0, 1'b0, 32'h48,   32'hDEAD,      32'h0};
        tbl[5] = '{1'b1, 1'b0, 32'h1000, 32'h0,         1'b1, 1'b1, 1'b0, 32'h1000, 32'h0,         32'h5A5A_1000};
        for (int i = 0; i < 6; i++) begin
            s_req = tbl[i].s_req; s_we = tbl[i].s_we; s_addr = tbl[i].s_addr; s_wdata = tbl[i].s_wdata;
            settle();
            check($sformatf("tbl%0d gnt", i), VW'(s_gnt), VW'(tbl[i].e_gnt));
            check($sformatf("tbl%0d rd/wr", i), VW'({mem_read, mem_write}), VW'({tbl[i].e_rd, tbl[i].e_wr}));
            check($sformatf("tbl%0d addr", i), VW'(mem_addr), VW'(tbl[i].e_addr));
            check($sformatf("tbl%0d wdata", i), VW'(mem_wdata), VW'(tbl[i].e_wdata));
            check($sformatf("tbl%0d stall", i), VW'(cpu_stall), VW'(0));
            if (tbl[i].e_rd) check($sformatf("tbl%0d rdata", i), VW'(s_rdata), VW'(tbl[i].e_rdata));
            tick();
        end
        idle_inputs();
        ref_mem[32'h44] = 32'h1234_5678;

        // Directed vector load, store, contention and negative stride.
        preload(32'h100, 32'd11);
        preload(32'h104, 32'd22);
        preload(32'h108, 32'd33);
        preload(32'h10C, 32'd44);
        run_vec("vload", 1'b0, 32'h100, 32'd4, '0, -1, '0);
        check("vload packed", v_rdata, {32'd44, 32'd33, 32'd22, 32'd11});
        run_vec("vstore", 1'b1, 32'h200, 32'd8,
                {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA}, -1, '0);
        check("vstore elem0", VW'(dut_rd(32'h200)), VW'(32'hAAAA_AAAA));
        check("vstore elem3", VW'(dut_rd(32'h218)), VW'(32'hDDDD_DDDD));
        run_vec("contend", 1'b0, 32'h300, 32'd4, '0, 2, 32'h40);
        run_vec("negstride", 1'b0, 32'h4, 32'hFFFF_FFFC, '0, -1, '0);
        run_vec("simul", 1'b0, 32'h100, 32'd4, '0, 0, 32'h44);

        // Back-to-back: store is presented the cycle right after the load's DONE.
        run_vec("b2b_ld", 1'b0, 32'h200, 32'd8, '0, -1, '0);
        run_vec("b2b_st", 1'b1, 32'h600, 32'd4,
                {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001}, -1, '0);

        // Reset after two store elements have been written.
        w0 = wr_count;
        v_start = 1'b1; v_we = 1'b1; v_base = 32'h400; v_stride = 32'd4;
        v_wdata = {32'hE3, 32'hE2, 32'hE1, 32'hE0};
        for (int cyc = 0; cyc < 3; cyc++) begin
            settle();
            tick();
        end
        rst = 1'b1;
        settle();
        check("rstmid no write", VW'(mem_write), VW'(0));
        tick();
        rst = 1'b0;
        v_start = 1'b0;
        ref_mem[32'h400] = 32'hE0;
        ref_mem[32'h404] = 32'hE1;
        exp_vrdata = '0;
        check("rstmid writes", VW'(wr_count - w0), VW'(2));
        for (int i = 0; i < 3; i++)
            check($sformatf("rstmid mem%0d", i), VW'(dut_rd(32'h400 + 32'(4 * i))), VW'(ref_rd(32'h400 + 32'(4 * i))));
        for (int cyc = 0; cyc < 3; cyc++) begin
            settle();
            check($sformatf("rstmid c%0d stall", cyc), VW'(cpu_stall), VW'(0));
            check($sformatf("rstmid c%0d done", cyc), VW'(v_done), VW'(0));
            check($sformatf("rstmid c%0d v_rdata", cyc), v_rdata, exp_vrdata);
            tick();
        end

        // Randomized instruction mix against the model.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                scalar_op(1'($urandom_range(0, 1)), 32'h500 + 32'(4 * $urandom_range(0, 15)), $urandom);
            end else begin
                for (int i = 0; i < N; i++) wd[i*EW +: EW] = $urandom;
                base = ($urandom_range(0, 1) == 1) ? 32'h500 + 32'(4 * $urandom_range(0, 15)) : $urandom;
                case ($urandom_range(0, 4))
                    0: stride = 32'd4;
                    1: stride = 32'd8;
                    2: stride = 32'hFFFF_FFFC;
                    3: stride = 32'd0;
                    default: stride = $urandom;
                endcase
                run_vec($sformatf("rnd%0d", it), 1'($urandom_range(0, 1)), base, stride, wd,
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N + 1)) : -1,
                        32'h500 + 32'(4 * $urandom_range(0, 15)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
